// File: rtl/imem_loader_if.sv
// Byte-stream channel feeding the instruction-memory loader.
// Ports: rx_data (byte), rx_valid (source has a byte), rx_ready (sink accepts).
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader that assembles little-endian words into the
// instruction RAM and holds the CPU in reset while a frame is loading.
// Ports: clk, reset (sync, active high), start (frame begin pulse),
//   rx (byte stream, slave side), we/waddr/wdata (RAM write strobe),
//   cpu_hold (CPU reset request), busy, done, error (sticky status).
module imem_loader #(
    parameter int N  = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  rx,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [N-1:0]  wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int BYTES = N / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] word_cnt;
    logic [AW-1:0] last_addr;
    logic [BW-1:0] byte_cnt;
    logic [N-1:0]  asm_word;
    logic [7:0]    csum;
    logic          xfer;

    assign xfer = rx.rx_valid & rx.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        rx.rx_ready = 1'b0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                done  = (state == DONE);
                error = (state == ERR);
                if (start) state_nx = HDR;
            end
            HDR: begin
                rx.rx_ready = 1'b1;
                busy        = 1'b1;
                if (rx.rx_valid)
                    state_nx = rx.rx_data[7] ? ERR : DATA;
            end
            DATA: begin
                rx.rx_ready = 1'b1;
                busy        = 1'b1;
                if (rx.rx_valid && byte_cnt == BW'(BYTES - 1))
                    state_nx = WRITE;
            end
            WRITE: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = word_cnt;
                wdata = asm_word;
                state_nx = (word_cnt == last_addr) ? CSUM : DATA;
            end
            CSUM: begin
                rx.rx_ready = 1'b1;
                busy        = 1'b1;
                if (rx.rx_valid)
                    state_nx = (rx.rx_data == csum) ? DONE : ERR;
            end
            default: state_nx = IDLE;
        endcase
        // The CPU is held exactly while a frame is in flight.
        cpu_hold = busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt  <= '0;
            last_addr <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            csum      <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                    end
                end
                HDR: begin
                    if (xfer) last_addr <= rx.rx_data[AW-1:0];
                end
                DATA: begin
                    if (xfer) begin
                        asm_word[{byte_cnt, 3'd0} +: 8] <= rx.rx_data;
                        csum     <= csum ^ rx.rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    byte_cnt <= '0;
                    // Stop at last_addr so a full-depth frame never wraps.
                    if (word_cnt != last_addr)
                        word_cnt <= word_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
